// File: rtl/or_operand_loader_if.sv
// Operand-loader bus: a serial bit stream in, and a registered operand pair out.
// Ports: sin/sin_valid/sin_ready form the serial side; a_out/b_out/pair_valid/pair_ready
// form the pair side; overrun/clr_overrun carry the sticky error flag and its clear.
interface or_operand_loader_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_valid;
    logic             sin_ready;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             pair_valid;
    logic             pair_ready;
    logic             overrun;
    logic             clr_overrun;

    // The loader itself.
    modport slave (
        input  sin, sin_valid, pair_ready, clr_overrun,
        output sin_ready, a_out, b_out, pair_valid, overrun
    );

    // The stream source and pair consumer.
    modport master (
        output sin, sin_valid, pair_ready, clr_overrun,
        input  sin_ready, a_out, b_out, pair_valid, overrun
    );
endinterface

// File: rtl/or_operand_loader.sv
// Deserialises a 1-bit MSB-first stream into operand A then B and holds the pair for the OR stage.
// Latency: pair_valid rises the cycle after the 2*WIDTH-th accepted bit; minimum pair period 2*WIDTH+1.
// Backpressure: sin_ready drops while a pair is held; bits offered then are dropped and flag overrun.
// Ports: clk, rst (sync, active high); bus = or_operand_loader_if.slave carrying
// sin/sin_valid/sin_ready, a_out/b_out/pair_valid/pair_ready, overrun/clr_overrun.
module or_operand_loader #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    or_operand_loader_if.slave   bus
);
    // Wide enough to hold WIDTH-1, and never zero bits wide.
    localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = (WIDTH == 1) ? CW'(0) : CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        HOLD
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] sr_a;
    logic [WIDTH-1:0] sr_b;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             pair_valid_q;
    logic             overrun_q;
    logic             sin_ready;
    logic             xfer;
    logic             last_bit;

    // Shift one bit in at the LSB; written via a wider temporary so WIDTH==1 needs no special case.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr, input logic b);
        logic [WIDTH:0] tmp;
        tmp = {sr, b};
        return tmp[WIDTH-1:0];
    endfunction

    assign xfer     = bus.sin_valid && sin_ready;
    assign last_bit = (bit_cnt == CNT_LAST);

    // Next state and sin_ready; sin_ready depends on state only.
    always_comb begin
        state_d   = state_q;
        sin_ready = 1'b0;
        case (state_q)
            IDLE: begin
                sin_ready = 1'b1;
                if (xfer) state_d = (WIDTH == 1) ? LOAD_B : LOAD_A;
            end
            LOAD_A: begin
                sin_ready = 1'b1;
                if (xfer && last_bit) state_d = LOAD_B;
            end
            LOAD_B: begin
                sin_ready = 1'b1;
                if (xfer && last_bit) state_d = HOLD;
            end
            HOLD: begin
                if (bus.pair_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: bit counter, shift registers and the held output pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt      <= '0;
            sr_a         <= '0;
            sr_b         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            pair_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        sr_a    <= shift_in(sr_a, bus.sin);
                        bit_cnt <= CNT_ONE;
                    end
                end
                LOAD_A: begin
                    if (xfer) begin
                        sr_a    <= shift_in(sr_a, bus.sin);
                        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
                        sr_b    <= shift_in(sr_b, bus.sin);
                        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                        if (last_bit) begin
                            // Take the final B bit straight from sin so the pair appears one cycle earlier.
                            a_q          <= sr_a;
                            b_q          <= shift_in(sr_b, bus.sin);
                            pair_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Operands are kept after acceptance; only the valid flag drops.
                    if (bus.pair_ready) pair_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Sticky overrun: a new drop wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (bus.sin_valid && !sin_ready) begin
            overrun_q <= 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.sin_ready  = sin_ready;
    assign bus.a_out      = a_q;
    assign bus.b_out      = b_q;
    assign bus.pair_valid = pair_valid_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_or_operand_loader.sv
// Directed bench for or_operand_loader at WIDTH=4: reset, basic/gapped loads, backpressure,
// overrun, reset mid-load and back-to-back pairs, with hand-computed expectations.
module tb_or_operand_loader;
    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   t1;
    int   t2;

    or_operand_loader_if #(.WIDTH(4)) bus ();

    or_operand_loader #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Stream A then B MSB first, inserting 'gap' idle cycles between bits.
    // Returns in the cycle right after the 8th transfer, with sin_valid low.
    task automatic send_pair(input logic [3:0] a, input logic [3:0] b, input int gap, input string tag);
        logic [7:0] bits;
        bits = {a, b};
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    bus.sin_valid = 1'b0;
                    step();
                    check({tag, "_pv_gap"}, 32'(bus.pair_valid), 32'd0);
                end
            end
            check({tag, "_pv_load"}, 32'(bus.pair_valid), 32'd0);
            bus.sin       = bits[7-i];
            bus.sin_valid = 1'b1;
            step();
        end
        bus.sin_valid = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.sin         = 1'b0;
        bus.sin_valid   = 1'b0;
        bus.pair_ready  = 1'b0;
        bus.clr_overrun = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_a",       32'(bus.a_out),      32'h0);
        check("rst_b",       32'(bus.b_out),      32'h0);
        check("rst_pv",      32'(bus.pair_valid), 32'd0);
        check("rst_ovr",     32'(bus.overrun),    32'd0);
        check("rst_sin_rdy", 32'(bus.sin_ready),  32'd1);

        // Basic pair: bits 1010 0110, consumer ready
        bus.pair_ready = 1'b1;
        send_pair(4'hA, 4'h6, 0, "basic");
        check("basic_pv",  32'(bus.pair_valid),          32'd1);
        check("basic_a",   32'(bus.a_out),               32'hA);
        check("basic_b",   32'(bus.b_out),               32'h6);
        check("basic_y",   32'(bus.a_out | bus.b_out),   32'hE);
        check("basic_rdy", 32'(bus.sin_ready),           32'd0);
        step();
        check("basic_pv_1cyc", 32'(bus.pair_valid), 32'd0);
        check("basic_rdy_idle", 32'(bus.sin_ready), 32'd1);
        check("basic_a_kept", 32'(bus.a_out), 32'hA);

        // Gapped input: idle cycle between every bit
        send_pair(4'hA, 4'h6, 1, "gap");
        check("gap_pv", 32'(bus.pair_valid), 32'd1);
        check("gap_a",  32'(bus.a_out),      32'hA);
        check("gap_b",  32'(bus.b_out),      32'h6);
        step();
        check("gap_pv_drop", 32'(bus.pair_valid), 32'd0);

        // Backpressure: pair held for 10 cycles
        bus.pair_ready = 1'b0;
        send_pair(4'h5, 4'h9, 0, "bp");
        for (int i = 0; i < 10; i++) begin
            check("bp_pv",  32'(bus.pair_valid), 32'd1);
            check("bp_a",   32'(bus.a_out),      32'h5);
            check("bp_b",   32'(bus.b_out),      32'h9);
            check("bp_rdy", 32'(bus.sin_ready),  32'd0);
            step();
        end
        bus.pair_ready = 1'b1;
        step();
        check("bp_pv_release", 32'(bus.pair_valid), 32'd0);
        check("bp_rdy_release", 32'(bus.sin_ready), 32'd1);

        // Overrun: a bit offered during HOLD is dropped and flagged
        bus.pair_ready = 1'b0;
        send_pair(4'h1, 4'h2, 0, "ovr");
        bus.sin       = 1'b1;
        bus.sin_valid = 1'b1;
        step();
        bus.sin_valid = 1'b0;
        check("ovr_set",  32'(bus.overrun),    32'd1);
        check("ovr_pv",   32'(bus.pair_valid), 32'd1);
        check("ovr_a",    32'(bus.a_out),      32'h1);
        bus.pair_ready = 1'b1;
        step();
        send_pair(4'h3, 4'h4, 0, "ovr2");
        check("ovr_next_a",  32'(bus.a_out),   32'h3);
        check("ovr_next_b",  32'(bus.b_out),   32'h4);
        check("ovr_sticky",  32'(bus.overrun), 32'd1);
        step();
        bus.clr_overrun = 1'b1;
        step();
        bus.clr_overrun = 1'b0;
        check("ovr_clr", 32'(bus.overrun), 32'd0);

        // Simultaneous set and clear: set wins
        bus.pair_ready = 1'b0;
        send_pair(4'h7, 4'h8, 0, "ovr3");
        bus.sin_valid   = 1'b1;
        bus.clr_overrun = 1'b1;
        step();
        bus.sin_valid = 1'b0;
        check("ovr_set_wins", 32'(bus.overrun), 32'd1);
        step();
        bus.clr_overrun = 1'b0;
        check("ovr_clr2", 32'(bus.overrun), 32'd0);
        bus.pair_ready = 1'b1;
        step();
        check("ovr3_release", 32'(bus.pair_valid), 32'd0);

        // Reset mid-load after 5 bits
        for (int i = 0; i < 5; i++) begin
            bus.sin       = 1'b1;
            bus.sin_valid = 1'b1;
            step();
        end
        bus.sin_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_pv",  32'(bus.pair_valid), 32'd0);
        check("mid_rst_a",   32'(bus.a_out),      32'h0);
        check("mid_rst_rdy", 32'(bus.sin_ready),  32'd1);
        send_pair(4'h3, 4'hC, 0, "mid");
        check("mid_pv", 32'(bus.pair_valid), 32'd1);
        check("mid_a",  32'(bus.a_out),      32'h3);
        check("mid_b",  32'(bus.b_out),      32'hC);
        step();

        // Back-to-back with pair_ready tied high
        send_pair(4'hF, 4'h0, 0, "b2b1");
        t1 = cyc;
        check("b2b1_pv", 32'(bus.pair_valid),        32'd1);
        check("b2b1_y",  32'(bus.a_out | bus.b_out), 32'hF);
        step();
        send_pair(4'h0, 4'hF, 0, "b2b2");
        t2 = cyc;
        check("b2b2_pv", 32'(bus.pair_valid),        32'd1);
        check("b2b2_a",  32'(bus.a_out),             32'h0);
        check("b2b2_y",  32'(bus.a_out | bus.b_out), 32'hF);
        check("b2b_period", 32'(t2 - t1),            32'd9);
        check("b2b_no_ovr", 32'(bus.overrun),        32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
